// File: rtl/spi_responder_pkg.sv
// Shared constants and state encoding for the SPI responder.
package spi_responder_pkg;

  localparam int BYTE_BITS = 8;
  localparam int BIT_CNT_W = 3;

  typedef logic [0:0] state_t;
  localparam state_t IDLE   = 1'b0;
  localparam state_t ACTIVE = 1'b1;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-stage synchroniser for an asynchronous pin, with rise/fall strobes
// derived from the synchronised value and its one-cycle-delayed copy.
module spi_input_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, which is what makes this a shift chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
      last_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      last_q <= sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~last_q;
  assign fall_o = ~sync_q[STAGES-1] & last_q;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 target endpoint: oversampled pins, MSB-first byte exchange,
// valid/ready TX holding register and a one-cycle RX strobe.
module spi_responder
  import spi_responder_pkg::*;
#(
  parameter int         sync_stages = 2,
  parameter logic [7:0] idle_fill   = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       underrun
);

  logic sck_rise, sck_fall, sck_sync_unused;
  logic cs_sync, cs_fall, cs_rise_unused;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  spi_input_sync #(.STAGES(sync_stages), .RESET_VAL(1'b0)) u_sck_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (spi_sck),
    .sync_o  (sck_sync_unused),
    .rise_o  (sck_rise),
    .fall_o  (sck_fall)
  );

  // CS chain resets to "selected": a select held through reset produces no
  // falling edge, so a new frame only starts after CS has been seen high.
  spi_input_sync #(.STAGES(sync_stages), .RESET_VAL(1'b0)) u_cs_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (spi_cs_n),
    .sync_o  (cs_sync),
    .rise_o  (cs_rise_unused),
    .fall_o  (cs_fall)
  );

  spi_input_sync #(.STAGES(sync_stages), .RESET_VAL(1'b0)) u_mosi_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (spi_mosi),
    .sync_o  (mosi_sync),
    .rise_o  (mosi_rise_unused),
    .fall_o  (mosi_fall_unused)
  );

  state_t                 state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BYTE_BITS-1:0]   rx_shift_q, rx_shift_d;
  logic [BYTE_BITS-1:0]   tx_shift_q, tx_shift_d;
  logic [BYTE_BITS-1:0]   hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic                   reload_q, reload_d;
  logic [BYTE_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   underrun_q, underrun_d;
  logic                   load;
  logic                   accept;

  assign accept = tx_valid & ~hold_full_q;

  // NOTE: every variable written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    reload_d    = reload_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = ACTIVE;
          bit_cnt_d = '0;
          reload_d  = 1'b0;
          load      = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_sync) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          reload_d  = 1'b0;
        end else if (sck_rise) begin
          rx_shift_d = {rx_shift_q[BYTE_BITS-2:0], mosi_sync};
          bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == BIT_CNT_W'(BYTE_BITS - 1)) begin
            rx_data_d  = {rx_shift_q[BYTE_BITS-2:0], mosi_sync};
            rx_valid_d = 1'b1;
            reload_d   = 1'b1;
          end
        end else if (sck_fall) begin
          if (reload_q) begin
            load     = 1'b1;
            reload_d = 1'b0;
          end else begin
            tx_shift_d = {tx_shift_q[BYTE_BITS-2:0], 1'b1};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The load sees holding as it was before any accept in this same cycle.
    if (load) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d = idle_fill;
        underrun_d = 1'b1;
      end
    end

    if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '1;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      reload_q    <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      reload_q    <= reload_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  assign spi_miso    = tx_shift_q[BYTE_BITS-1];
  assign spi_miso_oe = (state_q == ACTIVE);
  assign busy        = (state_q == ACTIVE);
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: bit-banged mode-0 master, TX feeder and
// an RX/underrun monitor, with expected bytes fixed by the stimulus.
module tb_spi_responder;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       spi_sck  = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       spi_miso, spi_miso_oe, tx_ready, rx_valid, busy, underrun;
  logic [7:0] rx_data;

  int checks   = 0;
  int failures = 0;
  int half     = 6;

  logic [7:0] rx_q[$];
  int         underrun_cnt  = 0;
  int         long_pulse    = 0;
  logic       rx_valid_prev = 1'b0;
  logic [7:0] mo_v[64];
  logic [7:0] to_v[64];

  spi_responder dut (
    .clk         (clk),
    .reset       (reset),
    .spi_sck     (spi_sck),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .busy        (busy),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_q.push_back(rx_data);
      if (rx_valid_prev) long_pulse++;
    end
    rx_valid_prev = rx_valid;
    if (underrun) underrun_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    int n = 0;
    while (!tx_ready && n < 1000) begin
      clks(1);
      n++;
    end
    check("tx_ready_wait", 32'(tx_ready), 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    clks(1);
    tx_valid = 1'b0;
  endtask

  // Mode-0 master: MOSI changes while SCK is low, MISO is sampled on the rise.
  task automatic spi_xfer(input logic [7:0] mo, input int nbits, input logic inj,
                          input logic [7:0] inj_data, output logic [7:0] mi);
    mi = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi = mo[i];
      clks(half);
      spi_sck = 1'b1;
      mi[i]   = spi_miso;
      clks(half);
      spi_sck = 1'b0;
    end
    if (inj) begin
      // Falling edge acts on the third clk edge after it is driven.
      clks(2);
      tx_data  = inj_data;
      tx_valid = 1'b1;
      clks(1);
      tx_valid = 1'b0;
      clks(half - 3);
    end else begin
      clks(half);
    end
  endtask

  initial begin
    logic [7:0] m;
    int base, u0;

    // Reset values
    clks(3);
    check("reset_vals", 32'({spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, busy, underrun}),
          32'({1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0}));
    reset = 1'b0;
    clks(half);

    // Single byte: A5 in, 3C out
    base = rx_q.size();
    u0   = underrun_cnt;
    push(8'h3C);
    check("t1_ready_low", 32'(tx_ready), 32'd0);
    spi_cs_n = 1'b0;
    clks(half);
    check("t1_ready_back", 32'(tx_ready), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_oe", 32'(spi_miso_oe), 32'd1);
    check("t1_no_underrun", 32'(underrun_cnt - u0), 32'd0);
    spi_xfer(8'hA5, 8, 1'b0, 8'h00, m);
    check("t1_miso", 32'(m), 32'h3C);
    check("t1_rx_count", 32'(rx_q.size() - base), 32'd1);
    check("t1_rx_byte", 32'(rx_q[base]), 32'hA5);
    check("t1_rx_data", 32'(rx_data), 32'hA5);
    spi_cs_n = 1'b1;
    clks(half);
    check("t1_idle", 32'({busy, spi_miso_oe}), 32'd0);

    // Three-byte burst, TX queued for two bytes only
    base = rx_q.size();
    push(8'h11);
    spi_cs_n = 1'b0;
    clks(half);
    u0 = underrun_cnt;
    push(8'h22);
    spi_xfer(8'h01, 8, 1'b0, 8'h00, m);
    check("t2_miso0", 32'(m), 32'h11);
    spi_xfer(8'h02, 8, 1'b0, 8'h00, m);
    check("t2_miso1", 32'(m), 32'h22);
    check("t2_underrun_third_load", 32'(underrun_cnt - u0), 32'd1);
    spi_xfer(8'h03, 8, 1'b0, 8'h00, m);
    check("t2_miso2", 32'(m), 32'hFF);
    spi_cs_n = 1'b1;
    clks(half);
    check("t2_rx_count", 32'(rx_q.size() - base), 32'd3);
    check("t2_rx0", 32'(rx_q[base]), 32'h01);
    check("t2_rx1", 32'(rx_q[base + 1]), 32'h02);
    check("t2_rx2", 32'(rx_q[base + 2]), 32'h03);

    // Abort after 5 bits; held byte survives into the next frame
    base = rx_q.size();
    spi_cs_n = 1'b0;
    clks(half);
    push(8'h5A);
    spi_xfer(8'hF0, 5, 1'b0, 8'h00, m);
    spi_cs_n = 1'b1;
    clks(half);
    check("t3_no_rx", 32'(rx_q.size() - base), 32'd0);
    check("t3_idle", 32'(busy), 32'd0);
    check("t3_hold_kept", 32'(tx_ready), 32'd0);
    spi_cs_n = 1'b0;
    clks(half);
    spi_xfer(8'h80, 8, 1'b0, 8'h00, m);
    check("t3_miso", 32'(m), 32'h5A);
    spi_cs_n = 1'b1;
    clks(half);
    check("t3_rx_count", 32'(rx_q.size() - base), 32'd1);
    check("t3_rx", 32'(rx_q[base]), 32'h80);

    // tx_valid in the exact cycle of the boundary load with holding empty
    base = rx_q.size();
    u0   = underrun_cnt;
    spi_cs_n = 1'b0;
    clks(half);
    spi_xfer(8'h33, 8, 1'b1, 8'hC3, m);
    check("t4_miso0", 32'(m), 32'hFF);
    check("t4_held", 32'(tx_ready), 32'd0);
    check("t4_underruns", 32'(underrun_cnt - u0), 32'd2);
    spi_xfer(8'h44, 8, 1'b0, 8'h00, m);
    check("t4_miso1", 32'(m), 32'hFF);
    spi_xfer(8'h55, 8, 1'b0, 8'h00, m);
    check("t4_miso2", 32'(m), 32'hC3);
    spi_cs_n = 1'b1;
    clks(half);
    check("t4_rx_count", 32'(rx_q.size() - base), 32'd3);
    check("t4_rx2", 32'(rx_q[base + 2]), 32'h55);

    // Reset mid-byte with CS held low
    push(8'h77);
    spi_cs_n = 1'b0;
    clks(half);
    spi_xfer(8'hFF, 3, 1'b0, 8'h00, m);
    reset = 1'b1;
    clks(1);
    check("t5_reset_vals", 32'({spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, busy, underrun}),
          32'({1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0}));
    reset = 1'b0;
    clks(half);
    base = rx_q.size();
    u0   = underrun_cnt;
    spi_xfer(8'hAA, 8, 1'b0, 8'h00, m);
    check("t5_still_idle", 32'({busy, spi_miso_oe}), 32'd0);
    check("t5_no_rx", 32'(rx_q.size() - base), 32'd0);
    check("t5_no_underrun", 32'(underrun_cnt - u0), 32'd0);
    spi_cs_n = 1'b1;
    clks(half);
    spi_cs_n = 1'b0;
    clks(half);
    check("t5_busy_after_toggle", 32'(busy), 32'd1);
    spi_xfer(8'h96, 8, 1'b0, 8'h00, m);
    check("t5_miso", 32'(m), 32'hFF);
    spi_cs_n = 1'b1;
    clks(half);
    check("t5_rx", 32'(rx_q[base]), 32'h96);

    // 64 random bytes at the minimum half-period
    half = 4;
    for (int k = 0; k < 64; k++) begin
      mo_v[k] = 8'($urandom);
      to_v[k] = 8'($urandom);
    end
    base = rx_q.size();
    fork
      begin : feeder
        for (int k = 0; k < 64; k++) push(to_v[k]);
      end
      begin : master
        logic [7:0] mi;
        spi_cs_n = 1'b0;
        clks(half);
        for (int k = 0; k < 64; k++) begin
          spi_xfer(mo_v[k], 8, 1'b0, 8'h00, mi);
          check("t6_miso", 32'(mi), 32'(to_v[k]));
        end
        spi_cs_n = 1'b1;
        clks(half);
      end
    join
    check("t6_rx_count", 32'(rx_q.size() - base), 32'd64);
    for (int k = 0; k < 64; k++) check("t6_rx", 32'(rx_q[base + k]), 32'(mo_v[k]));

    check("rx_valid_single_cycle", 32'(long_pulse), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_responder.md
Name: spi_responder

Overview:
- SPI target (slave) endpoint: the other end of the SPI master that VirtualToplevel uses to drive the SD card.
- Lets an external controller (MCU, BBB header) exchange bytes with the SoC over spi_sck, spi_cs_n, spi_mosi and spi_miso.
- Protocol: mode 0 (CPOL=0, CPHA=0), MSB-first, 8-bit frames.
- SPI pins are oversampled in the clk domain. The CPU side gets a valid/ready TX holding register and a one-cycle RX strobe.

Parameters:
- sync_stages, 2, flip-flop stages on each SPI input before edge detection (≥2)
- idle_fill, 8'hFF, byte shifted out when no TX byte is queued at a byte boundary

Ports:
- clk  in  1  system clock (sysclk)
- reset  in  1  synchronous, active-high reset
- spi_sck  in  1  external SPI clock, asynchronous to clk
- spi_cs_n  in  1  external chip select, active low, asynchronous
- spi_mosi  in  1  data from master
- spi_miso  out  1  data to master
- spi_miso_oe  out  1  pad output enable for spi_miso
- tx_data  in  8  next byte to transmit
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  holding register empty; transfer occurs when tx_valid & tx_ready
- rx_data  out  8  last complete received byte
- rx_valid  out  1  one-cycle strobe; rx_data is new
- busy  out  1  synchronised CS is active
- underrun  out  1  one-cycle strobe; idle_fill was loaded because holding was empty

Behaviour:
- Reset values: spi_miso=1, spi_miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, underrun=0. Holding register empty, bit counter 0, state IDLE.
- Reset asserted mid-transfer aborts immediately. After reset, the block waits for spi_cs_n to be seen high before honouring a new select.
- Synchronisation: sck, cs_n and mosi each pass through sync_stages flip-flops. Edges are detected on the last two stages. Detection latency is sync_stages+1 clk.
- Requirement on the master: SCK high and low phases each ≥ 4 clk periods.
- State IDLE → ACTIVE on a detected cs_n falling edge:
  - bit counter := 0; busy := 1; spi_miso_oe := 1
  - TX shift register loaded from holding if full (holding empties), else idle_fill with underrun pulse
  - spi_miso = shift[7] from the next cycle
- ACTIVE, rising sck: rx_shift := {rx_shift[6:0], mosi}; bit counter increments, 3-bit, wrapping 7 → 0.
- ACTIVE, rising sck with counter==7:
  - rx_data := {rx_shift[6:0], mosi}
  - rx_valid pulses 1 cycle (the cycle after the edge is detected)
  - reload flag set
- ACTIVE, falling sck:
  - reload flag set: TX shift loaded (holding or idle_fill/underrun as at CS entry); flag cleared.
  - otherwise: shift left by one.
- ACTIVE → IDLE on cs_n rising edge, or on cs_n seen high at any time:
  - spi_miso_oe := 0; busy := 0
  - partial RX bits discarded, no rx_valid
  - partial TX byte discarded; the holding register is untouched
- rx_valid has no backpressure. A consumer that misses it loses that byte.
- tx_ready = ~holding_full, registered.
- Simultaneous holding accept and load in the same cycle: the load sees the pre-accept state.
  - Holding empty: idle_fill is sent and the new byte stays in holding for the next frame.
  - Holding full: the load empties it and tx_ready rises next cycle. No bypass path.
- sck edges while IDLE are ignored.
- Back-to-back bytes without CS release are supported indefinitely.

Decomposition:
- Package spi_responder_pkg:
  - state enum {IDLE, ACTIVE}
  - constant BYTE_BITS=8
  - bit counter width (3)
- Sub-module spi_input_sync: parameterised synchroniser with rise/fall edge outputs. Instantiated for sck and cs_n; mosi uses the synchroniser only.

Test Plan:
- Reset, then cs low and 8 sck with MOSI=0xA5, tx_data=0x3C queued before CS → rx_data=0xA5 with rx_valid for exactly 1 cycle; master samples 0x3C on MISO; tx_ready back to 1 after CS entry.
- 3-byte burst under one CS, MOSI 0x01,0x02,0x03, TX queued only for 0x11 then 0x22 → three rx_valid strobes with data 01,02,03; MISO bytes 11,22,FF; one underrun pulse, on the third load.
- CS raised after 5 bits → no rx_valid; next full frame with MOSI 0x80 → rx_data=0x80; the holding byte queued before the abort is still transmitted.
- tx_valid asserted in the exact cycle of the byte-boundary load while holding is empty → 0xFF sent and underrun pulses; the queued byte goes out in the following frame.
- Reset asserted mid-byte → all outputs at reset values next cycle; with CS held low through reset, no transfer until CS toggles high then low.
- SCK at the minimum 4-clk half-period, random 64 bytes → all RX/TX bytes match the scoreboard.
